// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped, write-through, no-write-allocate data cache
//               controller producing the pipeline advance qualifier `hit`.
//               Optional macro DCACHE_STATS_EN adds hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
  parameter int LINES  = 16,
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int c_TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_MISS = 2'd1,
    S_WR_THRU = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  logic [LINES-1:0]    r_valid;
  logic [c_TAG_W-1:0]  r_tag  [LINES];
  logic [31:0]         r_data [LINES];
  logic [31:0]         r_fill;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;

  logic [IDX_W-1:0]    w_idx;
  logic [c_TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]    w_m_idx;
  logic [c_TAG_W-1:0]  w_m_tag;
  logic                w_lookup;
  logic                w_wr_match;
  logic                w_load_hit;
  logic                w_unused_addr_lo;

  assign w_idx            = cpu_addr[IDX_W+1:2];
  assign w_tag            = cpu_addr[ADDR_W-1:IDX_W+2];
  assign w_m_idx          = r_mem_addr[IDX_W+1:2];
  assign w_m_tag          = r_mem_addr[ADDR_W-1:IDX_W+2];
  assign w_lookup         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_wr_match       = r_valid[w_m_idx] && (r_tag[w_m_idx] == w_m_tag);
  assign w_load_hit       = (r_state == S_IDLE) && cpu_rd && !cpu_wr && w_lookup;
  assign w_unused_addr_lo = ^cpu_addr[1:0];

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Invalid lines read as zero so the output is deterministic right after reset.
  always_comb begin
    hit       = 1'b0;
    cpu_rdata = r_valid[w_idx] ? r_data[w_idx] : 32'd0;
    case (r_state)
      S_IDLE:  hit = !(cpu_rd || cpu_wr) || w_load_hit;
      S_DONE:  begin
        hit       = 1'b1;
        cpu_rdata = r_fill;
      end
      default: hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_fill      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_wr) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
            r_mem_wdata <= cpu_wdata;
            r_state     <= S_WR_THRU;
          end else if (cpu_rd && !w_lookup) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {cpu_addr[ADDR_W-1:2], 2'b00};
            r_state    <= S_RD_MISS;
          end
        end
        S_RD_MISS: begin
          if (mem_ack) begin
            r_valid[w_m_idx] <= 1'b1;
            r_fill           <= mem_rdata;
            r_mem_req        <= 1'b0;
            r_state          <= S_DONE;
          end
        end
        S_WR_THRU: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag/data storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (r_state == S_RD_MISS && mem_ack) begin
      r_tag[w_m_idx]  <= w_m_tag;
      r_data[w_m_idx] <= mem_rdata;
    end else if (r_state == S_WR_THRU && mem_ack && w_wr_match) begin
      r_data[w_m_idx] <= r_mem_wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_misses;

  assign stat_hits   = r_stat_hits;
  assign stat_misses = r_stat_misses;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
    end else begin
      if (w_load_hit)
        r_stat_hits <= r_stat_hits + 32'd1;
      if (r_state == S_IDLE && cpu_rd && !cpu_wr && !w_lookup)
        r_stat_misses <= r_stat_misses + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Self-checking bench for dcache_ctrl (table-driven vectors plus
//               reset-during-refill and optional DCACHE_STATS_EN sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  localparam int c_ACK_DLY = 4;
  localparam int c_NVEC    = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        hit, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  int          cmp_cnt = 0;
  int          err_cnt = 0;
  logic        resp_en = 1'b1;
  logic [31:0] mem_resp_data = '0;
  int          resp_cnt = 0;

  dcache_ctrl #(.LINES(16), .IDX_W(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .hit(hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: ack arrives in the c_ACK_DLY-th cycle of mem_req.
  always @(negedge clk) begin
    if (resp_en) begin
      if (mem_req && !mem_ack) begin
        resp_cnt++;
        if (resp_cnt == c_ACK_DLY) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_resp_data;
          resp_cnt  = 0;
        end
      end else begin
        mem_ack  = 1'b0;
        resp_cnt = 0;
      end
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic        exp_mem;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [c_NVEC];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] mrd,
                              input logic exp_mem, input logic [31:0] exp_rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.mrd = mrd; v.exp_mem = exp_mem; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic chk(input int id, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL [%0d] %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  task automatic do_txn(input int id, input vec_t v);
    int          stall;
    logic        saw, done;
    logic        got_we;
    logic [31:0] got_addr, got_wd, got_rd;
    stall = 0; saw = 1'b0; done = 1'b0;
    got_we = 1'b0; got_addr = '0; got_wd = '0; got_rd = '0;
    @(negedge clk);
    cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
    mem_resp_data = v.mrd;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (mem_req && !saw) begin
        saw = 1'b1; got_we = mem_we; got_addr = mem_addr; got_wd = mem_wdata;
      end
      if (hit) begin
        done = 1'b1; got_rd = cpu_rdata;
      end else begin
        stall++;
      end
    end
    if (!done) begin
      cmp_cnt++; err_cnt++;
      $display("FAIL [%0d] timeout: hit never rose, expected within 40 cycles", id);
    end else begin
      chk(id, "mem_txn", {31'd0, saw}, {31'd0, v.exp_mem});
      chk(id, "stall", stall, v.exp_mem ? 32'd5 : 32'd0);
      if (v.exp_mem) begin
        chk(id, "mem_we", {31'd0, got_we}, {31'd0, v.wr});
        chk(id, "mem_addr", got_addr, {v.addr[31:2], 2'b00});
        if (v.wr) chk(id, "mem_wdata", got_wd, v.wdata);
      end
      if (v.rd && !v.wr) chk(id, "cpu_rdata", got_rd, v.exp_rdata);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 32'h0000_0040, 0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
    vecs[1]  = mk(1, 0, 32'h0000_0040, 0, 0,             0, 32'hDEAD_BEEF);
    vecs[2]  = mk(1, 0, 32'h0000_0080, 0, 32'hA5A5_0080, 1, 32'hA5A5_0080);
    vecs[3]  = mk(1, 0, 32'h0000_0040, 0, 32'hCAFE_0040, 1, 32'hCAFE_0040);
    vecs[4]  = mk(1, 0, 32'h0000_0044, 0, 32'h1111_1111, 1, 32'h1111_1111);
    vecs[5]  = mk(0, 1, 32'h0000_0044, 32'h2222_2222, 0, 1, 0);
    vecs[6]  = mk(1, 0, 32'h0000_0047, 0, 0,             0, 32'h2222_2222);
    vecs[7]  = mk(0, 1, 32'h0000_00C8, 32'h3333_3333, 0, 1, 0);
    vecs[8]  = mk(1, 0, 32'h0000_00C8, 0, 32'h4444_4444, 1, 32'h4444_4444);
    vecs[9]  = mk(1, 1, 32'h0000_0010, 32'h5555_5555, 0, 1, 0);
    vecs[10] = mk(1, 0, 32'h0000_0010, 0, 32'h6666_6666, 1, 32'h6666_6666);
    vecs[11] = mk(1, 0, 32'h1000_0040, 0, 32'h9999_9999, 1, 32'h9999_9999);
    vecs[12] = mk(0, 1, 32'h1000_0040, 32'hABCD_1234, 0, 1, 0);
    vecs[13] = mk(1, 0, 32'h1000_0040, 0, 0,             0, 32'hABCD_1234);
    vecs[14] = mk(1, 0, 32'h0000_0040, 0, 32'h0BAD_F00D, 1, 32'h0BAD_F00D);
    vecs[15] = mk(1, 0, 32'h0000_0040, 0, 0,             0, 32'h0BAD_F00D);
    vecs[16] = mk(1, 0, 32'h0000_00C8, 0, 0,             0, 32'h4444_4444);

    repeat (2) @(negedge clk);
    #1;
    chk(100, "rst_hit", {31'd0, hit}, 32'd1);
    chk(100, "rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk(100, "rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk(100, "rst_mem_addr", mem_addr, 32'd0);
    chk(100, "rst_mem_wdata", mem_wdata, 32'd0);
    chk(100, "rst_cpu_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < c_NVEC; i++) do_txn(i, vecs[i]);
    go_idle();

    // Reset while a refill is outstanding, then a stray ack.
    resp_en = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0200;
    repeat (3) @(negedge clk);
    #1;
    chk(200, "refill_req", {31'd0, mem_req}, 32'd1);
    chk(200, "refill_hit", {31'd0, hit}, 32'd0);
    rst = 1'b0; cpu_rd = 1'b0;
    #1;
    chk(201, "async_rst_req", {31'd0, mem_req}, 32'd0);
    chk(201, "async_rst_hit", {31'd0, hit}, 32'd1);
    chk(201, "async_rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFEED_FACE;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk(202, "stray_ack_req", {31'd0, mem_req}, 32'd0);
    chk(202, "stray_ack_hit", {31'd0, hit}, 32'd1);
    resp_en = 1'b1;
    do_txn(203, mk(1, 0, 32'h0000_0200, 0, 32'h1234_5678, 1, 32'h1234_5678));
    do_txn(204, mk(1, 0, 32'h0000_0040, 0, 32'h7777_7777, 1, 32'h7777_7777));
    go_idle();

`ifdef DCACHE_STATS_EN
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk(300, "stat_hits_rst", stat_hits, 32'd0);
    chk(300, "stat_misses_rst", stat_misses, 32'd0);
    do_txn(301, mk(1, 0, 32'h0000_0040, 0, 32'hC0DE_0001, 1, 32'hC0DE_0001));
    for (int k = 0; k < 3; k++)
      do_txn(302 + k, mk(1, 0, 32'h0000_0040, 0, 0, 0, 32'hC0DE_0001));
    do_txn(305, mk(0, 1, 32'h0000_0040, 32'h0000_0005, 0, 1, 0));
    go_idle();
    #1;
    chk(306, "stat_misses", stat_misses, 32'd1);
    chk(306, "stat_hits", stat_hits, 32'd3);
    force dut.r_stat_hits = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_stat_hits;
    do_txn(307, mk(1, 0, 32'h0000_0040, 0, 0, 0, 32'h0000_0005));
    go_idle();
    #1;
    chk(308, "stat_hits_wrap", stat_hits, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
